// File: rtl/uart_tx_param.sv
// +----------------------------------------------------------------------+
// | uart_tx_param: parametrised UART transmitter with valid/ready input  |
// | handshake, optional parity and 1 or 2 stop bits.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
      $error("uart_tx_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;

  logic baud_last;
  logic accept;

  assign baud_last = (baud_q == BAUD_LAST);
  assign tx_ready  = (state_q == S_IDLE) ||
                     ((state_q == S_STOP) && (bit_q == STOP_LAST) && baud_last);
  assign accept    = tx_valid && tx_ready;
  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;

    if (state_q != S_IDLE) begin
      baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: tx_d = 1'b1;
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Accept is only possible in IDLE or the final stop cycle; it overrides both.
    if (accept) begin
      state_d = S_START;
      tx_d    = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = tx_data;
      par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_param.sv
// +----------------------------------------------------------------------+
// | tb_uart_tx_param: directed scoreboard bench for uart_tx_param.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] vld;
  logic [7:0] data [4];
  wire        txs  [4];
  wire        rdy  [4];
  wire        bsy  [4];

  always #5 clk = ~clk;

  // u0: defaults, u1: even parity, u2: odd parity, u3: even parity + 2 stop bits
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_valid(vld[0]), .tx_data(data[0]),
    .tx_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_valid(vld[1]), .tx_data(data[1]),
    .tx_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_valid(vld[2]), .tx_data(data[2]),
    .tx_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]));
  uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_valid(vld[3]), .tx_data(data[3]),
    .tx_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]));

  typedef struct packed {
    logic tx;
    logic ready;
    logic busy;
  } exp_t;

  exp_t exp_q[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic chk(input string tag, input logic obs, input logic expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Expected per-cycle tx/ready/busy for one frame at 4 clocks per bit.
  task automatic push_frame(input logic [7:0] d, input int pm, input int sb);
    logic bits[$];
    int   ones;
    logic p;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pm != 0) begin
      ones = $countones(d);
      p = (ones % 2 == 1) ? (pm == 2) : (pm == 1);
      bits.push_back(p);
    end
    for (int i = 0; i < sb; i++) bits.push_back(1'b1);
    for (int i = 0; i < bits.size(); i++) begin
      for (int c = 0; c < 4; c++) begin
        exp_q.push_back('{tx: bits[i], ready: (i == bits.size() - 1) && (c == 3), busy: 1'b1});
      end
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{tx: 1'b1, ready: 1'b1, busy: 1'b0});
  endtask

  // Samples n cycles on the falling edge against the scoreboard. After the
  // first sample tx_data becomes nd; tx_valid drops after cycle drop_at;
  // junk scribbles on tx_valid/tx_data mid-frame while ready is low.
  task automatic run(input int d, input int n, input int drop_at,
                     input logic [7:0] nd, input bit junk, input string tag);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $error("FAIL %s c%0d: observed output with empty scoreboard, expected entry", tag, c);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("%s tx c%0d", tag, c), txs[d], e.tx);
        chk($sformatf("%s ready c%0d", tag, c), rdy[d], e.ready);
        chk($sformatf("%s busy c%0d", tag, c), bsy[d], e.busy);
      end
      if (c == 0) data[d] = nd;
      if (c == drop_at) vld[d] = 1'b0;
      if (junk && c >= 6 && c <= 20) begin
        vld[d]  = c[0];
        data[d] = 8'(c * 37);
      end
      if (junk && c == 21) vld[d] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    vld = 4'hF;
    for (int i = 0; i < 4; i++) data[i] = 8'h96;

    // Reset held two cycles with valid asserted
    push_idle(2);
    run(0, 2, -1, 8'h96, 1'b0, "reset");
    rst = 1'b0;
    vld = 4'h0;
    push_idle(2);
    run(0, 2, -1, 8'h96, 1'b0, "post_reset");

    // Single frame 0x96
    data[0] = 8'h96;
    vld[0]  = 1'b1;
    push_frame(8'h96, 0, 1);
    push_idle(2);
    run(0, 42, 0, 8'h96, 1'b0, "single");

    // Back-to-back 0x96 then 0x0E with valid held
    data[0] = 8'h96;
    vld[0]  = 1'b1;
    push_frame(8'h96, 0, 1);
    push_frame(8'h0E, 0, 1);
    push_idle(2);
    run(0, 82, 45, 8'h0E, 1'b0, "b2b");

    // Parity and stop-bit variants
    data[1] = 8'h0E;
    vld[1]  = 1'b1;
    push_frame(8'h0E, 2, 1);
    push_idle(2);
    run(1, 46, 0, 8'h0E, 1'b0, "even");

    data[2] = 8'h0E;
    vld[2]  = 1'b1;
    push_frame(8'h0E, 1, 1);
    push_idle(2);
    run(2, 46, 0, 8'h0E, 1'b0, "odd");

    data[3] = 8'h0E;
    vld[3]  = 1'b1;
    push_frame(8'h0E, 2, 2);
    push_idle(2);
    run(3, 50, 0, 8'h0E, 1'b0, "even2stop");

    // Reset during data bit 3 of 0x96, then a clean 0x55 frame
    data[0] = 8'h96;
    vld[0]  = 1'b1;
    push_frame(8'h96, 0, 1);
    run(0, 18, 0, 8'h96, 1'b0, "pre_abort");
    exp_q.delete();
    rst = 1'b1;
    push_idle(1);
    run(0, 1, -1, 8'h96, 1'b0, "abort");
    rst = 1'b0;
    data[0] = 8'h55;
    vld[0]  = 1'b1;
    push_frame(8'h55, 0, 1);
    push_idle(2);
    run(0, 42, 0, 8'h55, 1'b0, "after_abort");

    // Input isolation: data and valid disturbed while busy
    data[0] = 8'hA3;
    vld[0]  = 1'b1;
    push_frame(8'hA3, 0, 1);
    push_idle(3);
    run(0, 43, 0, 8'h5C, 1'b1, "isolate");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
